branch_predictor_ctrl: RTL

//  Sequencer for the branch prediction path. Holds a table of 2-bit saturating counters indexed by fetch address and supplies the taken/not-taken prediction at fetch.

---
 rtl/branch_predictor_ctrl_pkg.sv | 9 +
 rtl/branch_predictor_ctrl_if.sv | 28 ++
 rtl/bp_counter_table.sv | 27 ++
 rtl/branch_predictor_ctrl.sv | 81 ++++++++
 4 files changed

// File: rtl/branch_predictor_ctrl_pkg.sv
// branch_predictor_ctrl_pkg: shared encodings and helpers for the branch prediction path
package branch_predictor_ctrl_pkg;
  localparam logic [1:0] CNT_RESET = 2'b01;
  typedef enum logic [1:0] {BT_NONE = 2'b00, BT_ZERO = 2'b01, BT_POS = 2'b10, BT_CARRY = 2'b11} branch_type_e;
  typedef enum logic [1:0] {ST_RUN = 2'b00, ST_FLUSH = 2'b01, ST_REDIRECT = 2'b10} state_e;
  function automatic logic [1:0] sat_update(input logic [1:0] c, input logic inc);
    return inc ? ((c == 2'b11) ? c : c + 2'b01) : ((c == 2'b00) ? c : c - 2'b01);
  endfunction
endpackage

// File: rtl/branch_predictor_ctrl_if.sv
// branch_predictor_ctrl_if: fetch, resolve and redirect signals between pipeline and predictor
interface branch_predictor_ctrl_if #(parameter int ADDR_W = 11, parameter int CNT_W = 16);
  logic              fetch_valid;
  logic              fetch_is_branch;
  logic [ADDR_W-1:0] fetch_addr;
  logic              predict_taken;
  logic              resolve_valid;
  logic [ADDR_W-1:0] resolve_addr;
  logic [1:0]        branch_type;
  logic              prediction_failed;
  logic              branch_result;
  logic [ADDR_W-1:0] failback_addr;
  logic              flush;
  logic              stall_fetch;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic [CNT_W-1:0]  mispredict_count;
  modport master (
    output fetch_valid, fetch_is_branch, fetch_addr, resolve_valid, resolve_addr,
           branch_type, prediction_failed, branch_result, failback_addr,
    input  predict_taken, flush, stall_fetch, redirect_valid, redirect_addr, mispredict_count
  );
  modport slave (
    input  fetch_valid, fetch_is_branch, fetch_addr, resolve_valid, resolve_addr,
           branch_type, prediction_failed, branch_result, failback_addr,
    output predict_taken, flush, stall_fetch, redirect_valid, redirect_addr, mispredict_count
  );
endinterface

// File: rtl/bp_counter_table.sv
// bp_counter_table: 2-bit saturating counter array, async read, single saturating-update write
module bp_counter_table
  import branch_predictor_ctrl_pkg::*;
#(
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_inc
);
  logic [1:0] cnt_q [2**IDX_W];
  logic [1:0] cnt_d [2**IDX_W];
  always_comb begin
    cnt_d = cnt_q;
    if (wr_en) cnt_d[wr_idx] = sat_update(cnt_q[wr_idx], wr_inc);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < 2**IDX_W; i++) cnt_q[i] <= CNT_RESET;
    else cnt_q <= cnt_d;
  end
  // reads the registered array only, so a same-cycle write is not bypassed
  assign rd_taken = cnt_q[rd_idx][1];
endmodule

// File: rtl/branch_predictor_ctrl.sv
// branch_predictor_ctrl: prediction lookup, table training and mispredict flush/redirect sequencing
module branch_predictor_ctrl
  import branch_predictor_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 11,
  parameter int IDX_W        = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  branch_predictor_ctrl_if.slave bus
);
  localparam int TMR_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  state_e            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              flush_q, flush_d, stall_q, stall_d, redir_q, redir_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [CNT_W-1:0]  mcnt_q, mcnt_d;
  logic              accept, fetch_taken;
  logic              unused_ok;
  assign accept = bus.resolve_valid && (bus.branch_type != BT_NONE) && (state_q == ST_RUN);
  bp_counter_table #(.IDX_W(IDX_W)) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_idx  (bus.fetch_addr[IDX_W-1:0]),
    .rd_taken(fetch_taken),
    .wr_en   (accept),
    .wr_idx  (bus.resolve_addr[IDX_W-1:0]),
    .wr_inc  (bus.branch_result)
  );
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    raddr_d = raddr_q;
    mcnt_d  = mcnt_q;
    case (state_q)
      ST_RUN: if (accept && bus.prediction_failed) begin
        state_d = ST_FLUSH;
        tmr_d   = TMR_W'(FLUSH_CYCLES - 1);
        raddr_d = bus.failback_addr;
        mcnt_d  = mcnt_q + CNT_W'(mcnt_q != '1);
      end
      ST_FLUSH: begin
        state_d = (tmr_q == '0) ? ST_REDIRECT : ST_FLUSH;
        tmr_d   = (tmr_q == '0) ? tmr_q : tmr_q - TMR_W'(1);
      end
      default: state_d = ST_RUN;
    endcase
    // outputs are flopped decodes of the next state so they come straight off registers
    flush_d = (state_d == ST_FLUSH);
    redir_d = (state_d == ST_REDIRECT);
    stall_d = flush_d | redir_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      tmr_q   <= '0;
      flush_q <= 1'b0;
      stall_q <= 1'b0;
      redir_q <= 1'b0;
      raddr_q <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      flush_q <= flush_d;
      stall_q <= stall_d;
      redir_q <= redir_d;
      raddr_q <= raddr_d;
      mcnt_q  <= mcnt_d;
    end
  end
  assign bus.predict_taken    = bus.fetch_valid & bus.fetch_is_branch & ~stall_q & fetch_taken;
  assign bus.flush            = flush_q;
  assign bus.stall_fetch      = stall_q;
  assign bus.redirect_valid   = redir_q;
  assign bus.redirect_addr    = raddr_q;
  assign bus.mispredict_count = mcnt_q;
  assign unused_ok = ^{bus.fetch_addr[ADDR_W-1:IDX_W], bus.resolve_addr[ADDR_W-1:IDX_W]};
endmodule
